// File: rtl/decode_stage_hs_if.sv
// Handshake and datapath bundle between fetch, register file, forwarding unit and EX
// for the decode stage.
interface decode_stage_hs_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned CNT_W  = 16
) ();
    logic              in_valid;
    logic              in_ready;
    logic [15:0]       instr;
    logic              flush;
    logic [2:0]        rs1_addr;
    logic [2:0]        rs2_addr;
    logic [DATA_W-1:0] rs1_data_in;
    logic [DATA_W-1:0] rs2_data_in;
    logic [1:0]        frwd_bz;
    logic [DATA_W-1:0] frwd_res_ex;
    logic [DATA_W-1:0] frwd_res_mem;
    logic [DATA_W-1:0] frwd_res_wb;
    logic              branch_taken;
    logic [5:0]        branch_offset_imm;
    logic              out_valid;
    logic              out_ready;
    logic [3:0]        opcode_reg_out;
    logic [2:0]        alu_cmd;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] store_data;
    logic [2:0]        op_dest;
    logic              mem_write_en;
    logic              wb_mux;
    logic              wb_en;
    logic [2:0]        fsrc1;
    logic [2:0]        fsrc2;
    logic              illegal_op;
    logic [CNT_W-1:0]  stall_cnt;

    // Environment side: fetch, register file, forwarding unit and EX.
    modport master (
        output in_valid, instr, flush, rs1_data_in, rs2_data_in, frwd_bz,
               frwd_res_ex, frwd_res_mem, frwd_res_wb, out_ready,
        input  in_ready, rs1_addr, rs2_addr, branch_taken, branch_offset_imm, out_valid,
               opcode_reg_out, alu_cmd, op_a, op_b, store_data, op_dest, mem_write_en,
               wb_mux, wb_en, fsrc1, fsrc2, illegal_op, stall_cnt
    );

    // Decode stage side.
    modport slave (
        input  in_valid, instr, flush, rs1_data_in, rs2_data_in, frwd_bz,
               frwd_res_ex, frwd_res_mem, frwd_res_wb, out_ready,
        output in_ready, rs1_addr, rs2_addr, branch_taken, branch_offset_imm, out_valid,
               opcode_reg_out, alu_cmd, op_a, op_b, store_data, op_dest, mem_write_en,
               wb_mux, wb_en, fsrc1, fsrc2, illegal_op, stall_cnt
    );
endinterface

// File: rtl/decode_stage_hs.sv
// 16-bit decode stage with valid/ready on both sides, load-use bubble insertion,
// branch resolution in ID, flush, illegal-opcode flagging and a saturating stall counter.
module decode_stage_hs #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned IMM_SIGNED = 1,
    parameter int unsigned CNT_W      = 16
) (
    input logic               clk,
    input logic               rst,
    decode_stage_hs_if.slave  bus
);
    localparam logic [3:0] OpNop  = 4'd0;
    localparam logic [3:0] OpAddi = 4'd9;
    localparam logic [3:0] OpLd   = 4'd10;
    localparam logic [3:0] OpSt   = 4'd11;
    localparam logic [3:0] OpBz   = 4'd12;
    localparam logic [3:0] OpBnz  = 4'd13;

    typedef struct packed {
        logic              valid;
        logic [3:0]        opcode;
        logic [2:0]        alu_cmd;
        logic [DATA_W-1:0] op_a;
        logic [DATA_W-1:0] op_b;
        logic [DATA_W-1:0] store_data;
        logic [2:0]        op_dest;
        logic              mem_write_en;
        logic              wb_mux;
        logic              wb_en;
        logic [2:0]        fsrc1;
        logic [2:0]        fsrc2;
        logic              illegal;
    } out_t;

    out_t              out_q, out_d, dec;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [3:0]        opcode;
    logic [2:0]        rd, rs1, rs2;
    logic [5:0]        imm;
    logic [DATA_W-1:0] imm_ext, branch_input;
    logic              is_alu, is_st, is_illegal, reads_rs1, reads_rs2;
    logic              hazard, advance, ready, accept;

    assign opcode     = bus.instr[15:12];
    assign rd         = bus.instr[11:9];
    assign rs1        = bus.instr[8:6];
    assign imm        = bus.instr[5:0];
    assign is_alu     = (opcode >= 4'd1) && (opcode <= 4'd8);
    assign is_st      = (opcode == OpSt);
    assign is_illegal = (opcode >= 4'd14);
    // ST reads its store data through the second port, addressed by the rd field.
    assign rs2        = is_st ? rd : bus.instr[5:3];
    assign reads_rs1  = (opcode != OpNop) && !is_illegal;
    assign reads_rs2  = is_alu || is_st;
    assign imm_ext    = {{(DATA_W-6){(IMM_SIGNED != 0) && imm[5]}}, imm};

    always_comb begin
        dec         = '0;
        dec.illegal = is_illegal;
        case (opcode)
            OpAddi, OpLd: begin
                dec.valid   = 1'b1;
                dec.opcode  = opcode;
                dec.op_a    = bus.rs1_data_in;
                dec.op_b    = imm_ext;
                dec.op_dest = rd;
                dec.wb_en   = (rd != 3'd0);
                dec.wb_mux  = (opcode == OpLd);
                dec.fsrc1   = rs1;
            end
            OpSt: begin
                dec.valid        = 1'b1;
                dec.opcode       = opcode;
                dec.op_a         = bus.rs1_data_in;
                dec.op_b         = imm_ext;
                dec.store_data   = bus.rs2_data_in;
                dec.mem_write_en = 1'b1;
                dec.fsrc1        = rs1;
                dec.fsrc2        = rs2;
            end
            default: begin
                if (is_alu) begin
                    dec.valid   = 1'b1;
                    dec.opcode  = opcode;
                    dec.alu_cmd = 3'(opcode - 4'd1);
                    dec.op_a    = bus.rs1_data_in;
                    dec.op_b    = bus.rs2_data_in;
                    dec.op_dest = rd;
                    dec.wb_en   = (rd != 3'd0);
                    dec.fsrc1   = rs1;
                    dec.fsrc2   = rs2;
                end
            end
        endcase
    end

    always_comb begin
        unique case (bus.frwd_bz)
            2'b10:   branch_input = bus.frwd_res_ex;
            2'b11:   branch_input = bus.frwd_res_mem;
            2'b01:   branch_input = bus.frwd_res_wb;
            default: branch_input = bus.rs1_data_in;
        endcase
    end

    // Load-use: the loaded value is not available until after MEM, so the consumer waits.
    assign hazard  = bus.in_valid && out_q.valid && (out_q.opcode == OpLd) &&
                     (out_q.op_dest != 3'd0) &&
                     ((reads_rs1 && (rs1 == out_q.op_dest)) ||
                      (reads_rs2 && (rs2 == out_q.op_dest)));
    assign advance = !out_q.valid || bus.out_ready;
    assign ready   = !bus.flush && !hazard && advance;
    assign accept  = bus.in_valid && ready;

    always_comb begin
        out_d = out_q;
        if (bus.flush) begin
            out_d = '0;
        end else if (advance) begin
            out_d = accept ? dec : '0;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (hazard && !bus.flush && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_q <= '0;
            cnt_q <= '0;
        end else begin
            out_q <= out_d;
            cnt_q <= cnt_d;
        end
    end

    assign bus.in_ready          = ready;
    assign bus.rs1_addr          = rs1;
    assign bus.rs2_addr          = rs2;
    assign bus.branch_offset_imm = imm;
    assign bus.branch_taken      = accept &&
                                   (((opcode == OpBz) && (branch_input == '0)) ||
                                    ((opcode == OpBnz) && (branch_input != '0)));
    assign bus.out_valid         = out_q.valid;
    assign bus.opcode_reg_out    = out_q.opcode;
    assign bus.alu_cmd           = out_q.alu_cmd;
    assign bus.op_a              = out_q.op_a;
    assign bus.op_b              = out_q.op_b;
    assign bus.store_data        = out_q.store_data;
    assign bus.op_dest           = out_q.op_dest;
    assign bus.mem_write_en      = out_q.mem_write_en;
    assign bus.wb_mux            = out_q.wb_mux;
    assign bus.wb_en             = out_q.wb_en;
    assign bus.fsrc1             = out_q.fsrc1;
    assign bus.fsrc2             = out_q.fsrc2;
    assign bus.illegal_op        = out_q.illegal;
    assign bus.stall_cnt         = cnt_q;
endmodule

// File: tb/tb_decode_stage_hs.sv
// Directed bench for decode_stage_hs: decode, load-use bubble, branches, back-pressure,
// flush, illegal opcode and asynchronous reset.
module tb_decode_stage_hs;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned CNT_W  = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    decode_stage_hs_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    decode_stage_hs #(
        .DATA_W     (DATA_W),
        .IMM_SIGNED (1),
        .CNT_W      (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [DATA_W-1:0] rf [8];
    always_comb begin
        bus.rs1_data_in = rf[bus.rs1_addr];
        bus.rs2_data_in = rf[bus.rs2_addr];
    end

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] ins(input logic [3:0] op, input logic [2:0] rd,
                                        input logic [2:0] rs1, input logic [5:0] low);
        return {op, rd, rs1, low};
    endfunction

    initial begin
        rf[0] = 16'h0000; rf[1] = 16'h0005; rf[2] = 16'h000A; rf[3] = 16'h0033;
        rf[4] = 16'h0007; rf[5] = 16'h0000; rf[6] = 16'h0000; rf[7] = 16'h0000;
        rst = 1'b0;
        bus.in_valid = 1'b0; bus.instr = 16'h0000; bus.flush = 1'b0; bus.out_ready = 1'b1;
        bus.frwd_bz = 2'b00; bus.frwd_res_ex = '0; bus.frwd_res_mem = '0; bus.frwd_res_wb = '0;
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_stall_cnt", bus.stall_cnt, 0);
        chk("rst_illegal", bus.illegal_op, 0);
        chk("rst_op_a", bus.op_a, 0);
        #11 rst = 1'b1;
        tick();

        // ALU opcode 3: rd=2, rs1=1 (5), rs2=4 (7)
        bus.instr = ins(4'd3, 3'd2, 3'd1, {3'd4, 3'd0}); bus.in_valid = 1'b1; #1;
        chk("alu_in_ready", bus.in_ready, 1);
        chk("alu_rs1_addr", bus.rs1_addr, 1);
        chk("alu_rs2_addr", bus.rs2_addr, 4);
        tick(); bus.in_valid = 1'b0; #1;
        chk("alu_out_valid", bus.out_valid, 1);
        chk("alu_cmd", bus.alu_cmd, 2);
        chk("alu_op_a", bus.op_a, 16'h0005);
        chk("alu_op_b", bus.op_b, 16'h0007);
        chk("alu_op_dest", bus.op_dest, 2);
        chk("alu_wb_en", bus.wb_en, 1);
        chk("alu_fsrc2", bus.fsrc2, 4);

        // ADDI rd=1, rs1=2 (10), imm=3E sign-extended
        bus.instr = ins(4'd9, 3'd1, 3'd2, 6'h3E); bus.in_valid = 1'b1;
        tick(); bus.in_valid = 1'b0; #1;
        chk("addi_op_a", bus.op_a, 16'h000A);
        chk("addi_op_b", bus.op_b, 16'hFFFE);
        chk("addi_fsrc2", bus.fsrc2, 0);
        chk("addi_wb_en", bus.wb_en, 1);

        // LD rd=3 followed by ADD reading rs1=3: one stall, one bubble
        bus.instr = ins(4'd10, 3'd3, 3'd2, 6'd1); bus.in_valid = 1'b1; #1;
        chk("ld_in_ready", bus.in_ready, 1);
        tick(); bus.instr = ins(4'd1, 3'd4, 3'd3, {3'd0, 3'd0}); #1;
        chk("ld_opcode", bus.opcode_reg_out, 10);
        chk("ld_wb_mux", bus.wb_mux, 1);
        chk("hz_in_ready", bus.in_ready, 0);
        tick(); #1;
        chk("hz_bubble", bus.out_valid, 0);
        chk("hz_stall_cnt", bus.stall_cnt, 1);
        chk("hz_in_ready_after", bus.in_ready, 1);
        tick(); bus.in_valid = 1'b0; #1;
        chk("hz_add_valid", bus.out_valid, 1);
        chk("hz_add_opcode", bus.opcode_reg_out, 1);
        chk("hz_add_op_a", bus.op_a, 16'h0033);
        chk("hz_stall_hold", bus.stall_cnt, 1);

        // Branches
        bus.instr = ins(4'd12, 3'd0, 3'd1, 6'h15); bus.frwd_bz = 2'b10; bus.frwd_res_ex = '0;
        bus.in_valid = 1'b1; #1;
        chk("bz_ex_taken", bus.branch_taken, 1);
        chk("bz_offset", bus.branch_offset_imm, 6'h15);
        bus.frwd_bz = 2'b11; bus.frwd_res_mem = 16'h0009; #1;
        chk("bz_mem_not_taken", bus.branch_taken, 0);
        bus.instr = ins(4'd13, 3'd0, 3'd0, 6'd5); bus.frwd_bz = 2'b00; #1;
        chk("bnz_rf_zero", bus.branch_taken, 0);
        bus.frwd_bz = 2'b01; bus.frwd_res_wb = 16'h0003; #1;
        chk("bnz_wb_taken", bus.branch_taken, 1);
        tick(); bus.in_valid = 1'b0; bus.frwd_bz = 2'b00; #1;
        chk("br_bubble", bus.out_valid, 0);

        // Back-pressure for three cycles after an ALU op
        bus.instr = ins(4'd5, 3'd3, 3'd1, {3'd4, 3'd0}); bus.in_valid = 1'b1;
        tick(); bus.out_ready = 1'b0; bus.instr = ins(4'd2, 3'd5, 3'd4, {3'd1, 3'd0}); #1;
        chk("bp_in_ready", bus.in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_valid_hold", bus.out_valid, 1);
            chk("bp_cmd_hold", bus.alu_cmd, 4);
            chk("bp_op_a_hold", bus.op_a, 16'h0005);
            chk("bp_in_ready_low", bus.in_ready, 0);
        end
        bus.out_ready = 1'b1; #1;
        chk("bp_release_ready", bus.in_ready, 1);
        tick(); bus.in_valid = 1'b0; #1;
        chk("bp_next_cmd", bus.alu_cmd, 1);
        chk("bp_next_op_a", bus.op_a, 16'h0007);
        chk("bp_next_op_b", bus.op_b, 16'h0005);
        chk("bp_next_dest", bus.op_dest, 5);

        // Flush during a valid (would-be-taken) BZ
        bus.instr = ins(4'd12, 3'd0, 3'd0, 6'd0); bus.in_valid = 1'b1; bus.flush = 1'b1; #1;
        chk("fl_taken", bus.branch_taken, 0);
        chk("fl_in_ready", bus.in_ready, 0);
        tick(); bus.flush = 1'b0; bus.in_valid = 1'b0; #1;
        chk("fl_out_valid", bus.out_valid, 0);
        chk("fl_stall_cnt", bus.stall_cnt, 1);

        // ST rd=4 (store data 7), rs1=1, imm=2
        bus.instr = ins(4'd11, 3'd4, 3'd1, 6'd2); bus.in_valid = 1'b1; #1;
        chk("st_rs2_addr", bus.rs2_addr, 4);
        tick(); bus.in_valid = 1'b0; #1;
        chk("st_op_b", bus.op_b, 16'h0002);
        chk("st_data", bus.store_data, 16'h0007);
        chk("st_mem_we", bus.mem_write_en, 1);
        chk("st_wb_en", bus.wb_en, 0);
        chk("st_op_dest", bus.op_dest, 0);
        chk("st_fsrc2", bus.fsrc2, 4);

        // ALU writing r0 has write-back suppressed
        bus.instr = ins(4'd1, 3'd0, 3'd1, {3'd4, 3'd0}); bus.in_valid = 1'b1;
        tick(); bus.in_valid = 1'b0; #1;
        chk("rd0_valid", bus.out_valid, 1);
        chk("rd0_wb_en", bus.wb_en, 0);

        // Illegal opcode pulses illegal_op for one cycle
        bus.instr = ins(4'd15, 3'd1, 3'd1, 6'd0); bus.in_valid = 1'b1;
        tick(); bus.in_valid = 1'b0; #1;
        chk("ill_pulse", bus.illegal_op, 1);
        chk("ill_no_op", bus.out_valid, 0);
        tick();
        chk("ill_clear", bus.illegal_op, 0);

        // Asynchronous reset mid-stream
        bus.instr = ins(4'd3, 3'd2, 3'd1, {3'd4, 3'd0}); bus.in_valid = 1'b1;
        tick(); bus.in_valid = 1'b0; #1;
        chk("pre_rst_valid", bus.out_valid, 1);
        #2 rst = 1'b0; #1;
        chk("arst_out_valid", bus.out_valid, 0);
        chk("arst_op_a", bus.op_a, 0);
        chk("arst_wb_en", bus.wb_en, 0);
        chk("arst_stall_cnt", bus.stall_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/decode_stage_hs.md
Name: decode_stage_hs

Overview:
- Parametrised successor of the 16-bit pipeline decode stage.
- Decodes one 16-bit instruction per cycle, reads the register file and resolves BZ/BNZ in ID.
- Replaces the bare stall inputs with valid/ready handshakes on both sides.
- Adds internal load-use hazard detection (bubble insertion), flush, illegal-opcode flagging and a saturating stall counter.
- Sits between the fetch stage and the EX stage.

Parameters:
- DATA_W, 16, datapath width of register and operand values.
- IMM_SIGNED, 1, 1: 6-bit immediate is sign-extended to DATA_W; 0: zero-extended.
- CNT_W, 16, width of the stall counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  instr holds a valid instruction.
- in_ready  out  1  stage accepts instr this cycle.
- instr  in  16  fields: opcode[15:12], rd[11:9], rs1[8:6], rs2[5:3], imm[5:0].
- flush  in  1  kill the in-flight decode and the output register.
- rs1_addr, rs2_addr  out  3  register-file read addresses.
- rs1_data_in, rs2_data_in  in  DATA_W  register-file read data.
- frwd_bz  in  2  branch operand select: 10 EX, 11 MEM, 01 WB, 00 register file.
- frwd_res_ex, frwd_res_mem, frwd_res_wb  in  DATA_W  forwarded results.
- branch_taken  out  1  combinational redirect to fetch.
- branch_offset_imm  out  6  instr[5:0].
- out_valid  out  1  the output register holds an operation.
- out_ready  in  1  EX accepts the operation.
- opcode_reg_out  out  4  registered opcode.
- alu_cmd  out  3  registered ALU command.
- op_a, op_b  out  DATA_W  registered operands.
- store_data  out  DATA_W  registered ST data.
- op_dest  out  3  registered destination register.
- mem_write_en, wb_mux, wb_en  out  1  registered control bits.
- fsrc1, fsrc2  out  3  source register ids for the forwarding unit; 0 means unused.
- illegal_op  out  1  registered one-cycle pulse.
- stall_cnt  out  CNT_W  number of hazard-stall cycles.

Behaviour:
- Reset (rst=0): every registered output is 0, including out_valid, illegal_op and stall_cnt.
- Address decode:
  - rs1_addr = instr[8:6].
  - rs2_addr = instr[11:9] for ST, otherwise instr[5:3].
- Opcodes:
  - 0 NOP.
  - 1-8 ALU: alu_cmd = opcode-1; op_a = rs1; op_b = rs2.
  - 9 ADDI and 10 LD: op_b = ext(imm); fsrc2 = 0; LD also sets wb_mux = 1.
  - 11 ST: op_b = ext(imm); store_data = rs2 data; mem_write_en = 1; op_dest = 0; wb_en = 0.
  - 12 BZ and 13 BNZ: produce no operation (out_valid = 0).
  - 14-15 illegal: treated as NOP, pulse illegal_op for one cycle.
- wb_en = 1 for ALU, ADDI and LD, but forced to 0 when rd = 0.
- Hazard:
  - hazard = out_valid && opcode_reg_out == LD && op_dest != 0 && the current instruction reads op_dest.
  - Reads: rs1 for every non-NOP opcode; rs2 for ALU and ST.
  - Qualified by in_valid.
- in_ready = !flush && !hazard && (!out_valid || out_ready).
- accept = in_valid && in_ready.
- Output register update:
  - Advances when !out_valid || out_ready.
  - On advance it loads the decoded operation, with out_valid = 1 when accept and the opcode produces an operation; otherwise it loads out_valid = 0 and all controls 0.
  - When not advancing, every output holds.
- Operand latency: one cycle from accept to the output register.
- Branch:
  - branch_input comes from the frwd_bz mux.
  - branch_taken = accept && ((BZ && branch_input == 0) || (BNZ && branch_input != 0)).
  - When branch_taken is 0 the branch is consumed as a bubble.
- flush has priority over everything:
  - in_ready = 0 and branch_taken = 0.
  - Next edge: out_valid = 0 and illegal_op = 0; stall_cnt is unchanged.
- stall_cnt increments in every cycle with in_valid && hazard && !flush, and saturates at all-ones.
- Back-pressure:
  - With out_valid = 1 and out_ready = 0, all outputs hold and in_ready = 0.
  - A hazard under back-pressure counts stall cycles but inserts no bubble until out_ready = 1.
- Reset asserted mid-operation clears the output register and counter immediately (asynchronous).

Test Plan:
- Reset, then ALU opcode 3 (rd=2, rs1=1 with 5, rs2=4 with 7) -> one cycle later out_valid = 1, alu_cmd = 2, op_a = 5, op_b = 7, op_dest = 2, wb_en = 1.
- ADDI rd=1, rs1=2 with 10, imm = 6'h3E -> op_b = 16'hFFFE (IMM_SIGNED=1) or 16'h003E (IMM_SIGNED=0); fsrc2 = 0.
- LD rd=3, then ADD reading rs1=3:
  - in_ready = 0 for one cycle, then one bubble (out_valid = 0).
  - ADD is accepted the next cycle; stall_cnt = 1.
- BZ with frwd_bz = 10 and frwd_res_ex = 0 -> branch_taken = 1 in the accept cycle, then out_valid = 0.
- BNZ with register value 0 -> branch_taken = 0.
- out_ready held 0 for 3 cycles after an ALU op -> outputs stable, in_ready = 0, nothing lost.
- flush during a valid BZ -> branch_taken = 0 and out_valid = 0 next cycle.
- Opcode 15 -> illegal_op pulses for one cycle.
- rst low mid-stream -> all outputs 0 immediately.
